difftest_log_event: RTL and testbench

Simulation-side performance-event logger that sits at the end of every `PERF` counter in the core. It samples a free-running cumulative event counter, computes wrap-safe per-cycle increments, keeps a 64-bit grand total and per-window statistics, and prints a tagged log line whenever a window closes. It is pure observation logic: it never feeds back into the core.

---
 rtl/difftest_pkg.sv | 15 +
 rtl/perf_delta_acc.sv | 31 +++
 rtl/difftest_log_event.sv | 97 +++++++++
 tb/tb_difftest_log_event.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest performance-event loggers.
package difftest_pkg;

    // Default sampling window length in cycles.
    localparam int PERF_WINDOW_DEFAULT = 1024;

    // Snapshot of one logger's observable statistics.
    // Window fields are widened to 64 bits so any counter WIDTH fits.
    typedef struct packed {
        logic [63:0] total;
        logic [63:0] windowDelta;
        logic [63:0] windowMax;
    } perf_evt_t;

endpackage

// File: rtl/perf_delta_acc.sv
// Wrap-safe per-cycle increment of a free-running cumulative counter
// plus a 64-bit grand total of all increments since reset.
module perf_delta_acc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] delta,
    output logic [63:0]      total
);

    logic [WIDTH-1:0] prev;

    // Modular subtraction: a counter wrap between samples still yields
    // the true increment as long as it stays below 2^WIDTH.
    assign delta = value - prev;

    // Remember the last sample and fold its increment into the total.
    // prev starts at 0 so the very first sample counts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= '0;
            total <= '0;
        end else begin
            prev  <= value;
            total <= total + 64'(delta);
        end
    end

endmodule

// File: rtl/difftest_log_event.sv
// Performance-event logger: per-cycle deltas, 64-bit total, per-window
// statistics and a tagged log line whenever a window closes.
// Pure observation logic; nothing here feeds back into the core.
module difftest_log_event
    import difftest_pkg::*;
#(
    parameter string NAME   = "event",
    parameter int    WIDTH  = 32,
    parameter int    WINDOW = PERF_WINDOW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       coreid,
    input  logic [WIDTH-1:0] value,
    input  logic             dump_req,
    output logic [63:0]      total,
    output logic [WIDTH-1:0] window_delta,
    output logic [WIDTH-1:0] window_max,
    output logic             window_valid,
    output logic [63:0]      cycle_cnt
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] winAcc;
    logic [WIDTH-1:0] winSum;
    logic [CNT_W-1:0] winCnt;
    logic             closeNow;

    // coreid only appears in log output
    logic unusedCoreid;
    assign unusedCoreid = ^coreid;

    perf_delta_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .delta (delta),
        .total (total)
    );

    // Window sum including this cycle's increment; wraps at WIDTH bits.
    assign winSum = winAcc + delta;

    // Natural end and forced dump coincide into a single close.
    assign closeNow = (winCnt == WIN_LAST) || dump_req;

    // Window accumulator, position counter and close reporting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winAcc       <= '0;
            winCnt       <= '0;
            window_delta <= '0;
            window_max   <= '0;
            window_valid <= 1'b0;
        end else if (closeNow) begin
            winAcc       <= '0;
            winCnt       <= '0;
            window_delta <= winSum;
            window_valid <= 1'b1;
            if (winSum > window_max) window_max <= winSum;
        end else begin
            winAcc       <= winSum;
            winCnt       <= winCnt + 1'b1;
            window_valid <= 1'b0;
        end
    end

    // Free-running cycle counter out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycle_cnt <= '0;
        else      cycle_cnt <= cycle_cnt + 64'd1;
    end

`ifdef DIFFTEST
    // Tagged log line on every close, showing the values being committed.
    always_ff @(posedge clk) begin
        if (rst && closeNow && DLog::logValid) begin
            $display("[%16d] [%s] core%0d total=%0d window=%0d",
                     cycle_cnt, NAME, coreid, total + 64'(delta), winSum);
        end
    end

    // End-of-run summary.
    final begin
        perf_evt_t evt;
        evt = '{total: total, windowDelta: 64'(window_delta), windowMax: 64'(window_max)};
        $display("[%s] core%0d summary total=%0d window_max=%0d",
                 NAME, coreid, evt.total, evt.windowMax);
    end
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Directed bench for difftest_log_event with a 4-cycle window.
module tb_difftest_log_event;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  coreid = 8'd0;
    logic [31:0] value = 32'd0;
    logic        dump_req = 1'b0;
    logic [63:0] total;
    logic [31:0] window_delta;
    logic [31:0] window_max;
    logic        window_valid;
    logic [63:0] cycle_cnt;

    int passCnt = 0;
    int checkCnt = 0;

    difftest_log_event #(
        .NAME   ("tb"),
        .WIDTH  (32),
        .WINDOW (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coreid       (coreid),
        .value        (value),
        .dump_req     (dump_req),
        .total        (total),
        .window_delta (window_delta),
        .window_max   (window_max),
        .window_valid (window_valid),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with value parked at v, then release.
    task automatic doReset(input logic [31:0] v);
        rst = 1'b0;
        value = v;
        dump_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        value = 32'd5;
        dump_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCnt++;
        if ({total, window_delta, window_max, window_valid, cycle_cnt} !== '0)
            $display("FAIL reset_outputs: got total=%0d wd=%0d wm=%0d wv=%0b cyc=%0d, want all 0",
                     total, window_delta, window_max, window_valid, cycle_cnt);
        else passCnt++;
        rst = 1'b1;
        step();
        checkCnt++;
        if (total !== 64'd5) $display("FAIL reset_first_total: got %0d want 5", total);
        else passCnt++;
        checkCnt++;
        if (cycle_cnt !== 64'd1) $display("FAIL reset_cycle_cnt: got %0d want 1", cycle_cnt);
        else passCnt++;
        step();
        checkCnt++;
        if (total !== 64'd5) $display("FAIL reset_total_hold: got %0d want 5", total);
        else passCnt++;
    endtask

    task automatic test_wrap();
        doReset(32'hFFFF_FFFE);
        step();
        checkCnt++;
        if (total !== 64'hFFFF_FFFE) $display("FAIL wrap_pre: got %0h want fffffffe", total);
        else passCnt++;
        value = 32'd3;
        step();
        checkCnt++;
        if (total !== 64'h1_0000_0003) $display("FAIL wrap_total: got %0h want 100000003", total);
        else passCnt++;
        step();
        step();
        // window of 4 samples: 0xFFFFFFFE + 5 + 0 + 0 wraps to 3
        checkCnt++;
        if (window_valid !== 1'b1 || window_delta !== 32'd3)
            $display("FAIL wrap_window: got wv=%0b wd=%0d want wv=1 wd=3", window_valid, window_delta);
        else passCnt++;
    endtask

    task automatic test_natural_window();
        doReset(32'd0);
        for (int i = 1; i <= 12; i++) begin
            value = 32'(i);
            step();
            checkCnt++;
            if (window_valid !== ((i % 4) == 0))
                $display("FAIL natural_valid[%0d]: got %0b want %0b", i, window_valid, (i % 4) == 0);
            else passCnt++;
            if ((i % 4) == 0) begin
                checkCnt++;
                if (window_delta !== 32'd4 || window_max !== 32'd4)
                    $display("FAIL natural_stats[%0d]: got wd=%0d wm=%0d want 4/4", i, window_delta, window_max);
                else passCnt++;
            end
        end
        checkCnt++;
        if (total !== 64'd12) $display("FAIL natural_total: got %0d want 12", total);
        else passCnt++;
    endtask

    task automatic test_early_close();
        doReset(32'd0);
        value = 32'd1;
        step();
        value = 32'd2;
        dump_req = 1'b1;
        step();
        checkCnt++;
        if (window_valid !== 1'b1 || window_delta !== 32'd2)
            $display("FAIL dump_close: got wv=%0b wd=%0d want wv=1 wd=2", window_valid, window_delta);
        else passCnt++;
        dump_req = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            value = 32'(i);
            step();
            checkCnt++;
            if (window_valid !== 1'b0) $display("FAIL dump_gap[%0d]: got wv=%0b want 0", i, window_valid);
            else passCnt++;
        end
        // dump coincides with the natural end of this window
        value = 32'd6;
        dump_req = 1'b1;
        step();
        checkCnt++;
        if (window_valid !== 1'b1 || window_delta !== 32'd4 || window_max !== 32'd4)
            $display("FAIL dump_coincide: got wv=%0b wd=%0d wm=%0d want 1/4/4",
                     window_valid, window_delta, window_max);
        else passCnt++;
        dump_req = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            value = 32'(i);
            step();
            checkCnt++;
            if (window_valid !== 1'b0) $display("FAIL dump_single[%0d]: got wv=%0b want 0", i, window_valid);
            else passCnt++;
        end
        value = 32'd10;
        step();
        checkCnt++;
        if (window_valid !== 1'b1 || window_delta !== 32'd4)
            $display("FAIL dump_restart: got wv=%0b wd=%0d want 1/4", window_valid, window_delta);
        else passCnt++;
    endtask

    task automatic test_max_tracking();
        logic [31:0] incs [12] = '{1, 1, 1, 0, 2, 2, 2, 1, 0, 1, 0, 1};
        logic [31:0] expD [3]  = '{3, 7, 2};
        logic [31:0] expM [3]  = '{3, 7, 7};
        logic [31:0] v;
        doReset(32'd0);
        v = 32'd0;
        for (int i = 0; i < 12; i++) begin
            v = v + incs[i];
            value = v;
            step();
            if ((i % 4) == 3) begin
                checkCnt++;
                if (window_valid !== 1'b1 || window_delta !== expD[i/4] || window_max !== expM[i/4])
                    $display("FAIL max_win%0d: got wv=%0b wd=%0d wm=%0d want 1/%0d/%0d",
                             i / 4, window_valid, window_delta, window_max, expD[i/4], expM[i/4]);
                else passCnt++;
            end
        end
    endtask

    task automatic test_mid_reset();
        doReset(32'd0);
        value = 32'd1;
        step();
        value = 32'd2;
        step();
        value = 32'd10;
        rst = 1'b0;
        #1;
        checkCnt++;
        if (window_valid !== 1'b0 || window_delta !== '0 || total !== '0 || cycle_cnt !== '0)
            $display("FAIL midreset_clear: got wv=%0b wd=%0d total=%0d cyc=%0d want all 0",
                     window_valid, window_delta, total, cycle_cnt);
        else passCnt++;
        step();
        step();
        checkCnt++;
        if (window_valid !== 1'b0 || window_delta !== '0)
            $display("FAIL midreset_hold: got wv=%0b wd=%0d want 0/0", window_valid, window_delta);
        else passCnt++;
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) value = 32'(9 + i);
            step();
            checkCnt++;
            if (window_valid !== (i == 4))
                $display("FAIL midreset_valid[%0d]: got %0b want %0b", i, window_valid, i == 4);
            else passCnt++;
        end
        checkCnt++;
        if (window_delta !== 32'd13 || total !== 64'd13)
            $display("FAIL midreset_window: got wd=%0d total=%0d want 13/13", window_delta, total);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_natural_window();
        test_early_close();
        test_max_tracking();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
